// File: rtl/sparc_exu_ccrwr_arb_pkg.sv
// Shared constants and types for the EXU CCR write-port arbiter.
// Optional statistics counters are enabled with CCRWR_ARB_STATS_EN.
package sparc_exu_ccrwr_arb_pkg;

    localparam int NTHR = 4;
    localparam int CCW  = 8;
    localparam int TIDW = 2;

    typedef logic [TIDW-1:0] tid_t;

    typedef struct packed {
        logic [3:0] xcc;
        logic [3:0] icc;
    } cc_t;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_TLU,
        SRC_PIPE,
        SRC_DIV,
        SRC_PEND
    } src_e;

endpackage

// File: rtl/sparc_exu_ccrwr_arb_rrpick.sv
// Round-robin first-set picker: lowest pending thread at or after ptr.
module sparc_exu_ccrwr_rrpick
    import sparc_exu_ccrwr_arb_pkg::*;
(
    input  logic [NTHR-1:0] vld,
    input  tid_t            ptr,
    output logic            pick_vld,
    output tid_t            pick_tid
);

    tid_t idx;

    // Walk offsets from far to near so the nearest hit is kept last.
    always_comb begin
        pick_vld = 1'b0;
        pick_tid = ptr;
        idx      = ptr;
        for (int i = NTHR - 1; i >= 0; i--) begin
            idx = ptr + tid_t'(i);
            if (vld[idx]) begin
                pick_vld = 1'b1;
                pick_tid = idx;
            end
        end
    end

endmodule

// File: rtl/sparc_exu_ccrwr_arb.sv
// EXU CCR write-port arbiter: TLU > pipe > div > pending drain.
// Define CCRWR_ARB_STATS_EN to add defer_cnt/drop_cnt counters.
module sparc_exu_ccrwr_arb
    import sparc_exu_ccrwr_arb_pkg::*;
(
    input  logic            clk,
    input  logic            arst_l,
    input  logic            tlu_wen_m,
    input  logic [TIDW-1:0] tlu_tid_m,
    input  logic [CCW-1:0]  tlu_cc_m,
    input  logic            pipe_wen_w,
    input  logic [TIDW-1:0] pipe_tid_w,
    input  logic [CCW-1:0]  pipe_cc_w,
    input  logic            div_wen_w2,
    input  logic [TIDW-1:0] div_tid_w2,
    input  logic [CCW-1:0]  div_cc_w2,
    input  logic [TIDW-1:0] rd_tid_d,
    output logic [NTHR-1:0] ccr_wen,
    output logic [CCW-1:0]  ccr_wdata,
    output logic            rd_pend_hit_d,
    output logic [CCW-1:0]  rd_pend_cc_d,
    output logic [NTHR-1:0] ccr_busy
`ifdef CCRWR_ARB_STATS_EN
    ,
    output logic [15:0]     defer_cnt,
    output logic [15:0]     drop_cnt
`endif
);

    logic [NTHR-1:0] pend_vld;
    cc_t             pend_cc [NTHR];
    tid_t            rr_ptr;

    logic pick_vld;
    tid_t pick_tid;

    logic pipe_live;
    logic div_live;
    logic pipe_defer;
    logic div_defer;
    src_e src;
    logic wen_any;
    tid_t wtid;
    cc_t  wdata;

    sparc_exu_ccrwr_rrpick u_rrpick (
        .vld      (pend_vld),
        .ptr      (rr_ptr),
        .pick_vld (pick_vld),
        .pick_tid (pick_tid)
    );

    // A newer write to the same thread cancels older ones; a pending
    // slot always holds a value newer than any arriving div result.
    always_comb begin
        pipe_live = pipe_wen_w
                  && !(tlu_wen_m && (tlu_tid_m == pipe_tid_w));
        div_live  = div_wen_w2
                  && !(tlu_wen_m && (tlu_tid_m == div_tid_w2))
                  && !(pipe_wen_w && (pipe_tid_w == div_tid_w2))
                  && !pend_vld[div_tid_w2];

        if (tlu_wen_m)      src = SRC_TLU;
        else if (pipe_live) src = SRC_PIPE;
        else if (div_live)  src = SRC_DIV;
        else if (pick_vld)  src = SRC_PEND;
        else                src = SRC_NONE;

        pipe_defer = pipe_live && (src != SRC_PIPE);
        div_defer  = div_live && (src != SRC_DIV);
    end

    always_comb begin
        wen_any = 1'b0;
        wtid    = '0;
        wdata   = '0;
        unique case (src)
            SRC_TLU: begin
                wen_any = 1'b1;
                wtid    = tlu_tid_m;
                wdata   = tlu_cc_m;
            end
            SRC_PIPE: begin
                wen_any = 1'b1;
                wtid    = pipe_tid_w;
                wdata   = pipe_cc_w;
            end
            SRC_DIV: begin
                wen_any = 1'b1;
                wtid    = div_tid_w2;
                wdata   = div_cc_w2;
            end
            SRC_PEND: begin
                wen_any = 1'b1;
                wtid    = pick_tid;
                wdata   = pend_cc[pick_tid];
            end
            default: begin
                wen_any = 1'b0;
            end
        endcase
        // Nothing reaches the CCR while reset is held.
        wen_any = wen_any && arst_l;
    end

    always_comb begin
        for (int i = 0; i < NTHR; i++) begin
            ccr_wen[i] = wen_any && (wtid == tid_t'(i));
        end
        ccr_wdata = wen_any ? wdata : '0;
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            pend_vld <= '0;
            rr_ptr   <= '0;
            for (int i = 0; i < NTHR; i++) begin
                pend_cc[i] <= '0;
            end
        end else begin
            if (tlu_wen_m) begin
                pend_vld[tlu_tid_m] <= 1'b0;
            end
            if (src == SRC_PIPE) begin
                pend_vld[pipe_tid_w] <= 1'b0;
            end
            if (src == SRC_PEND) begin
                pend_vld[pick_tid] <= 1'b0;
                rr_ptr             <= pick_tid + tid_t'(1);
            end
            if (pipe_defer) begin
                pend_vld[pipe_tid_w] <= 1'b1;
                pend_cc[pipe_tid_w]  <= pipe_cc_w;
            end
            if (div_defer) begin
                pend_vld[div_tid_w2] <= 1'b1;
                pend_cc[div_tid_w2]  <= div_cc_w2;
            end
        end
    end

    assign ccr_busy      = pend_vld;
    assign rd_pend_hit_d = pend_vld[rd_tid_d];
    assign rd_pend_cc_d  = pend_vld[rd_tid_d] ? pend_cc[rd_tid_d] : '0;

`ifdef CCRWR_ARB_STATS_EN
    logic        div_drop;
    logic [1:0]  defer_inc;
    logic [16:0] defer_sum;

    assign div_drop  = div_wen_w2 && !div_live;
    assign defer_inc = {1'b0, pipe_defer} + {1'b0, div_defer};
    assign defer_sum = {1'b0, defer_cnt} + {15'd0, defer_inc};

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            defer_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            defer_cnt <= defer_sum[16] ? 16'hFFFF : defer_sum[15:0];
            if (div_drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sparc_exu_ccrwr_arb.sv
// Self-checking bench for sparc_exu_ccrwr_arb: vector table, corner sequences, random vs model.
module tb_sparc_exu_ccrwr_arb;

    logic       clk;
    logic       arst_l;
    logic       tlu_wen_m;
    logic [1:0] tlu_tid_m;
    logic [7:0] tlu_cc_m;
    logic       pipe_wen_w;
    logic [1:0] pipe_tid_w;
    logic [7:0] pipe_cc_w;
    logic       div_wen_w2;
    logic [1:0] div_tid_w2;
    logic [7:0] div_cc_w2;
    logic [1:0] rd_tid_d;
    logic [3:0] ccr_wen;
    logic [7:0] ccr_wdata;
    logic       rd_pend_hit_d;
    logic [7:0] rd_pend_cc_d;
    logic [3:0] ccr_busy;

    int checks = 0;
    int errors = 0;

    sparc_exu_ccrwr_arb dut (
        .clk           (clk),
        .arst_l        (arst_l),
        .tlu_wen_m     (tlu_wen_m),
        .tlu_tid_m     (tlu_tid_m),
        .tlu_cc_m      (tlu_cc_m),
        .pipe_wen_w    (pipe_wen_w),
        .pipe_tid_w    (pipe_tid_w),
        .pipe_cc_w     (pipe_cc_w),
        .div_wen_w2    (div_wen_w2),
        .div_tid_w2    (div_tid_w2),
        .div_cc_w2     (div_cc_w2),
        .rd_tid_d      (rd_tid_d),
        .ccr_wen       (ccr_wen),
        .ccr_wdata     (ccr_wdata),
        .rd_pend_hit_d (rd_pend_hit_d),
        .rd_pend_cc_d  (rd_pend_cc_d),
        .ccr_busy      (ccr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending slots and drain pointer as plain arrays.
    bit   [3:0] pv;
    logic [7:0] pc [4];
    int         rr;
    bit   [3:0] npv;
    logic [7:0] npc [4];
    int         nrr;
    logic [3:0] m_wen;
    logic [7:0] m_wd;
    logic [3:0] m_busy;
    logic       m_hit;
    logic [7:0] m_rdcc;

    typedef struct {
        bit tw; int tt; logic [7:0] tc;
        bit pw; int pt; logic [7:0] pcv;
        bit dw; int dt; logic [7:0] dc;
        int rt;
        logic [3:0] wen; logic [7:0] wd; logic [3:0] busy;
        logic hit; logic [7:0] rdcc;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        pv = '0;
        rr = 0;
        for (int i = 0; i < 4; i++) pc[i] = 8'h00;
    endtask

    task automatic grant(input int t, input logic [7:0] v);
        m_wen  = 4'b0001 << t;
        m_wd   = v;
        npv[t] = 1'b0;
    endtask

    task automatic cyc_begin(input bit tw, input int tt, input logic [7:0] tc,
                             input bit pw, input int pt, input logic [7:0] pcv,
                             input bit dw, input int dt, input logic [7:0] dc,
                             input int rt);
        bit p_ok;
        bit d_ok;
        bit found;
        tlu_wen_m  = tw; tlu_tid_m  = 2'(tt); tlu_cc_m  = tc;
        pipe_wen_w = pw; pipe_tid_w = 2'(pt); pipe_cc_w = pcv;
        div_wen_w2 = dw; div_tid_w2 = 2'(dt); div_cc_w2 = dc;
        rd_tid_d   = 2'(rt);
        m_wen = 4'b0; m_wd = 8'h00;
        npv = pv; nrr = rr;
        for (int i = 0; i < 4; i++) npc[i] = pc[i];
        m_busy = pv;
        m_hit  = pv[rt];
        m_rdcc = pv[rt] ? pc[rt] : 8'h00;
        p_ok = pw && !(tw && tt == pt);
        d_ok = dw && !(tw && tt == dt) && !(pw && pt == dt) && !pv[dt];
        if (tw) grant(tt, tc);
        else if (p_ok) begin grant(pt, pcv); p_ok = 0; end
        else if (d_ok) begin grant(dt, dc); d_ok = 0; end
        else begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && pv[(rr + k) % 4]) begin
                    found = 1;
                    grant((rr + k) % 4, pc[(rr + k) % 4]);
                    nrr = ((rr + k) % 4 + 1) % 4;
                end
            end
        end
        if (p_ok) begin npv[pt] = 1'b1; npc[pt] = pcv; end
        if (d_ok) begin npv[dt] = 1'b1; npc[dt] = dc; end
        @(negedge clk);
    endtask

    task automatic cyc_end();
        pv = npv; rr = nrr;
        for (int i = 0; i < 4; i++) pc[i] = npc[i];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int rt);
        cyc_begin(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, rt);
    endtask

    function automatic vec_t mk(bit tw, int tt, logic [7:0] tc,
                                bit pw, int pt, logic [7:0] pcv,
                                bit dw, int dt, logic [7:0] dc, int rt,
                                logic [3:0] wen, logic [7:0] wd,
                                logic [3:0] busy, logic hit, logic [7:0] rdcc);
        vec_t v;
        v = '{tw, tt, tc, pw, pt, pcv, dw, dt, dc, rt, wen, wd, busy, hit, rdcc};
        return v;
    endfunction

    initial begin
        vt[0]  = mk(0,0,8'h00, 1,2,8'hA5, 0,0,8'h00, 0, 4'b0100,8'hA5,4'b0000,0,8'h00);
        vt[1]  = mk(0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 2, 4'b0000,8'h00,4'b0000,0,8'h00);
        vt[2]  = mk(1,1,8'h11, 1,3,8'h33, 0,0,8'h00, 0, 4'b0010,8'h11,4'b0000,0,8'h00);
        vt[3]  = mk(0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 3, 4'b1000,8'h33,4'b1000,1,8'h33);
        vt[4]  = mk(0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 3, 4'b0000,8'h00,4'b0000,0,8'h00);
        vt[5]  = mk(0,0,8'h00, 1,0,8'h0F, 1,0,8'hF0, 0, 4'b0001,8'h0F,4'b0000,0,8'h00);
        vt[6]  = mk(0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0, 4'b0000,8'h00,4'b0000,0,8'h00);
        vt[7]  = mk(0,0,8'h00, 1,1,8'h22, 1,2,8'h44, 0, 4'b0010,8'h22,4'b0000,0,8'h00);
        vt[8]  = mk(0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 2, 4'b0100,8'h44,4'b0100,1,8'h44);
        vt[9]  = mk(0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 2, 4'b0000,8'h00,4'b0000,0,8'h00);
        vt[10] = mk(0,0,8'h00, 0,0,8'h00, 1,3,8'h55, 0, 4'b1000,8'h55,4'b0000,0,8'h00);
        vt[11] = mk(1,0,8'h77, 1,1,8'h88, 1,2,8'h99, 0, 4'b0001,8'h77,4'b0000,0,8'h00);
        vt[12] = mk(0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 1, 4'b0010,8'h88,4'b0110,1,8'h88);
        vt[13] = mk(0,0,8'h00, 1,2,8'hAA, 0,0,8'h00, 2, 4'b0100,8'hAA,4'b0100,1,8'h99);
        vt[14] = mk(0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 2, 4'b0000,8'h00,4'b0000,0,8'h00);
        vt[15] = mk(1,0,8'h01, 1,3,8'hBB, 0,0,8'h00, 0, 4'b0001,8'h01,4'b0000,0,8'h00);
        vt[16] = mk(0,0,8'h00, 0,0,8'h00, 1,3,8'hCC, 3, 4'b1000,8'hBB,4'b1000,1,8'hBB);
        vt[17] = mk(0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 3, 4'b0000,8'h00,4'b0000,0,8'h00);

        // Reset with a request present: nothing may be written.
        arst_l = 1'b0;
        tlu_wen_m = 0; tlu_tid_m = 0; tlu_cc_m = 0;
        pipe_wen_w = 1; pipe_tid_w = 2'd1; pipe_cc_w = 8'h5A;
        div_wen_w2 = 0; div_tid_w2 = 0; div_cc_w2 = 0;
        rd_tid_d = 0;
        model_reset();
        #2;
        chk("rst_wen", ccr_wen, 4'b0000);
        chk("rst_wdata", ccr_wdata, 8'h00);
        chk("rst_busy", ccr_busy, 4'b0000);
        chk("rst_hit", rd_pend_hit_d, 1'b0);
        pipe_wen_w = 0;
        @(posedge clk); @(posedge clk);
        #1 arst_l = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cyc_begin(vt[i].tw, vt[i].tt, vt[i].tc, vt[i].pw, vt[i].pt, vt[i].pcv,
                      vt[i].dw, vt[i].dt, vt[i].dc, vt[i].rt);
            chk($sformatf("vec%0d_wen", i), ccr_wen, vt[i].wen);
            chk($sformatf("vec%0d_wdata", i), ccr_wdata, vt[i].wd);
            chk($sformatf("vec%0d_busy", i), ccr_busy, vt[i].busy);
            chk($sformatf("vec%0d_hit", i), rd_pend_hit_d, vt[i].hit);
            chk($sformatf("vec%0d_rdcc", i), rd_pend_cc_d, vt[i].rdcc);
            cyc_end();
        end

        // Build slots 0,1,3 with rr_ptr=1, then watch the drain order.
        cyc_begin(1,2,8'h02, 1,0,8'hD0, 0,0,8'h00, 0); cyc_end();
        idle(0);
        chk("rr_pre_wen", ccr_wen, 4'b0001);
        cyc_end();
        cyc_begin(1,2,8'h02, 1,1,8'hD1, 1,3,8'hD3, 0); cyc_end();
        cyc_begin(1,2,8'h02, 1,0,8'hE0, 0,0,8'h00, 0);
        chk("rr_busy_mid", ccr_busy, 4'b1010);
        cyc_end();
        idle(0);
        chk("rr_busy", ccr_busy, 4'b1011);
        chk("rr_d0_wen", ccr_wen, 4'b0010);
        chk("rr_d0_wd", ccr_wdata, 8'hD1);
        cyc_end();
        idle(0);
        chk("rr_d1_wen", ccr_wen, 4'b1000);
        chk("rr_d1_wd", ccr_wdata, 8'hD3);
        cyc_end();
        idle(0);
        chk("rr_d2_wen", ccr_wen, 4'b0001);
        chk("rr_d2_wd", ccr_wdata, 8'hE0);
        cyc_end();
        idle(0);
        chk("rr_done_busy", ccr_busy, 4'b0000);
        chk("rr_done_wen", ccr_wen, 4'b0000);
        cyc_end();

        // TLU restore cancels a pending slot for the same thread.
        cyc_begin(1,0,8'h03, 1,2,8'hC3, 0,0,8'h00, 2); cyc_end();
        cyc_begin(1,2,8'h7E, 0,0,8'h00, 0,0,8'h00, 2);
        chk("tlu_cancel_busy", ccr_busy, 4'b0100);
        chk("tlu_cancel_wen", ccr_wen, 4'b0100);
        chk("tlu_cancel_wd", ccr_wdata, 8'h7E);
        cyc_end();
        idle(2);
        chk("tlu_cancel_after_busy", ccr_busy, 4'b0000);
        chk("tlu_cancel_after_wen", ccr_wen, 4'b0000);
        cyc_end();

        // Reset in mid-operation drops pending slots immediately.
        cyc_begin(1,0,8'h04, 1,1,8'hB1, 1,3,8'hB3, 1); cyc_end();
        idle(1);
        chk("pre_rst_busy", ccr_busy, 4'b1010);
        chk("pre_rst_hit", rd_pend_hit_d, 1'b1);
        #2;
        arst_l = 1'b0;
        pipe_wen_w = 1; pipe_tid_w = 2'd2; pipe_cc_w = 8'h66;
        #1;
        chk("mid_rst_busy", ccr_busy, 4'b0000);
        chk("mid_rst_wen", ccr_wen, 4'b0000);
        chk("mid_rst_hit", rd_pend_hit_d, 1'b0);
        model_reset();
        @(posedge clk);
        #1 arst_l = 1'b1;
        idle(1);
        chk("post_rst_wen", ccr_wen, 4'b0000);
        chk("post_rst_busy", ccr_busy, 4'b0000);
        cyc_end();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            cyc_begin($urandom_range(0, 3) == 0, $urandom_range(0, 3), 8'($urandom),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 3), 8'($urandom),
                      $urandom_range(0, 2) == 0, $urandom_range(0, 3), 8'($urandom),
                      $urandom_range(0, 3));
            chk("rnd_wen", ccr_wen, m_wen);
            chk("rnd_wdata", ccr_wdata, m_wd);
            chk("rnd_busy", ccr_busy, m_busy);
            chk("rnd_hit", rd_pend_hit_d, m_hit);
            chk("rnd_rdcc", rd_pend_cc_d, m_rdcc);
            cyc_end();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sparc_exu_ccrwr_arb.md
Name: sparc_exu_ccrwr_arb

Overview:
- Arbitrates the single CCR write port of the EXU condition-code file among three sources:
  - TLU trap-restore (M stage)
  - ALU/WRCCR pipeline write (W stage)
  - Divider completion write (W2)
- A source that loses arbitration is parked in a per-thread pending slot and retired later.
- The pending value is bypassed to D-stage CC readers, and the IFU gets a per-thread busy indication.
- Sits between the ECL writeback control and the per-thread CCR storage flops.

Parameters:
- NTHR, 4, number of hardware threads; per-thread vectors are NTHR wide.
- CCW, 8, CC width {xcc[3:0], icc[3:0]}.
- TIDW, 2, thread-id width; NTHR == 2**TIDW.

Ports:
- clk  in  1  core clock.
- arst_l  in  1  asynchronous active-low reset.
- tlu_wen_m  in  1  TLU restore write request.
- tlu_tid_m  in  TIDW  TLU restore thread.
- tlu_cc_m  in  CCW  TLU restore data.
- pipe_wen_w  in  1  pipeline write request, already qualified by inst_vld and flush.
- pipe_tid_w  in  TIDW  pipeline write thread.
- pipe_cc_w  in  CCW  pipeline write data.
- div_wen_w2  in  1  divider write request.
- div_tid_w2  in  TIDW  divider write thread.
- div_cc_w2  in  CCW  divider write data.
- rd_tid_d  in  TIDW  D-stage read thread.
- ccr_wen  out  NTHR  one-hot write enable to CCR storage.
- ccr_wdata  out  CCW  write data.
- rd_pend_hit_d  out  1  pending slot valid for rd_tid_d.
- rd_pend_cc_d  out  CCW  pending data for rd_tid_d.
- ccr_busy  out  NTHR  pend_vld per thread; the IFU must not issue a new setcc/wrccr to a busy thread.

Behaviour:
- State:
  - pend_vld[NTHR] and pend_cc[NTHR][CCW].
  - Round-robin drain pointer rr_ptr[TIDW].
- Reset (async, arst_l low): pend_vld=0, pend_cc=0, rr_ptr=0.
  - Outputs: ccr_wen=0, ccr_wdata=0, ccr_busy=0, rd_pend_hit_d=0.
- Output timing:
  - ccr_wen and ccr_wdata are combinational from the current requests and pend state. The CCR storage captures on the next edge, so write latency is 0 cycles.
  - At most one bit of ccr_wen is set per cycle. ccr_wdata=0 when ccr_wen=0.
- Program-order rule, same thread: TLU restore is newest, then pipe W, then div W2.
  - A newer write to thread t cancels any older pending or concurrent write to t.
- Grant priority, one grant per cycle:
  1. TLU: always granted, never deferred. Clears pend_vld[tlu_tid]. A same-cycle pipe or div request to the same thread is dropped.
  2. Pipe direct.
  3. Div direct.
  4. Drain of pending slots, round-robin starting at rr_ptr.
- Pipe or div request not granted and not dropped: written into pend slot[tid]. pend_vld is set and pend_cc overwritten (newest wins).
- Pipe and div to the same thread in the same cycle: div is discarded, pipe proceeds.
- Div request to thread t while pend_vld[t]=1 (held by a pipe write): div is discarded.
- Pipe request to thread t while pend_vld[t]=1: the pipe value replaces the slot (if deferred), or is written directly and clears pend_vld[t] (if granted).
- Drain: granted only when no TLU, pipe or div grant occurs this cycle.
  - Picks the first pend_vld at or after rr_ptr. On grant, clears that slot and sets rr_ptr = drained tid + 1 (mod NTHR).
- A deferral and a drain of the same thread cannot coincide, because a new request for that thread supersedes the slot.
- Bypass: rd_pend_hit_d = pend_vld[rd_tid_d]; rd_pend_cc_d = pend_cc[rd_tid_d] when hit, else 0.
  - The ECL bypass mux places the pending slot between the E/M/W forward paths and the CCR storage read.
- Reset asserted mid-operation: all pending writes are lost; no write is issued while arst_l=0.

Optional Feature:
- CCRWR_ARB_STATS_EN defined:
  - Adds output defer_cnt (16 bits), a saturating count of deferral events. Resets to 0 and holds at 16'hFFFF.
  - Adds output drop_cnt (16 bits), a saturating count of discarded div writes.
- Not defined: neither port exists and no counter logic is synthesised.

Decomposition:
- Shared package:
  - CCW, TIDW and NTHR constants.
  - cc_t typedef ({xcc, icc}).
  - tid_t typedef.
  - Source enum: SRC_NONE, SRC_TLU, SRC_PIPE, SRC_DIV, SRC_PEND.
- One sub-module: sparc_exu_ccrwr_rrpick, the round-robin first-set picker taking pend_vld and rr_ptr and returning a valid flag and tid.

Test Plan:
- Pipe-only write, tid=2, cc=8'hA5 -> same cycle ccr_wen=4'b0100, ccr_wdata=8'hA5; no pending slot set.
- TLU tid=1 cc=8'h11 together with pipe tid=3 cc=8'h33:
  - Cycle 0: TLU is written; pend_vld[3]=1 and ccr_busy=4'b1000.
  - Cycle 1 (no requests): drain writes ccr_wen=4'b1000, ccr_wdata=8'h33; then ccr_busy=0.
- Pipe tid=0 cc=8'h0F together with div tid=0 cc=8'hF0 -> ccr_wdata=8'h0F, div discarded, no pending slot (stats variant: drop_cnt=1).
- Pipe tid=1 cc=8'h22 together with div tid=2 cc=8'h44:
  - Cycle 0: pipe is written; div deferred to slot 2.
  - With rd_tid_d=2: rd_pend_hit_d=1, rd_pend_cc_d=8'h44.
  - Cycle 1: slot 2 drains.
- Slots 0, 1 and 3 pending, rr_ptr=1, no requests -> drain order over 3 cycles is tid 1, 3, 0.
- Slot 2 pending, then TLU restore for tid 2 -> pend_vld[2] cleared and only the TLU value is written. Also assert arst_l low with slots pending -> ccr_busy=0 immediately and no drain after reset release.
